ddr_fifo_ctrl: RTL and testbench

DDR_FIFO_CTRL -- requirements
Module: ddr_fifo_ctrl

---
 rtl/ddr_fifo_ctrl_pkg.sv | 32 +++
 rtl/ddr_fifo_ctrl_fifo.sv | 46 ++++
 rtl/ddr_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_ddr_fifo_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_fifo_ctrl_pkg.sv
// ddr_fifo_ctrl_pkg: shared widths, FSM state encoding and address-advance helper for ddr_fifo_ctrl
package ddr_fifo_ctrl_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 24;
    localparam int BLEN_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_BURST = 3'd2,
        RD_REQ   = 3'd3,
        RD_BURST = 3'd4
    } state_t;

    // Advance by one burst; fall back to base when the following burst would run past last.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] last,
        input logic [BLEN_WIDTH-1:0] len
    );
        logic [ADDR_WIDTH:0] ext;
        logic [ADDR_WIDTH:0] n;
        logic [ADDR_WIDTH:0] lim;
        ext = {{(ADDR_WIDTH-BLEN_WIDTH+1){1'b0}}, len};
        n   = {1'b0, addr} + ext;
        lim = {1'b0, last} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        return (n + ext > lim) ? base : n[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/ddr_fifo_ctrl_fifo.sv
// ddr_sync_fifo: show-ahead synchronous FIFO with occupancy level output
module ddr_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && level != '0;
    assign push_ok = push && (!level[AW] || pop_ok);
    assign dout    = mem[rptr];

    // Pointers and level; a push into a full FIFO is taken only when a pop frees the head slot that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + AW'(push_ok);
            rptr  <= rptr + AW'(pop_ok);
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Storage array, left unreset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/ddr_fifo_ctrl.sv
// ddr_fifo_ctrl: burst arbiter between user write/read FIFOs and an SDRAM controller; DDR_FIFO_ERR_CNT_EN adds drop counters
module ddr_fifo_ctrl
    import ddr_fifo_ctrl_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 512,
    parameter logic [ADDR_WIDTH-1:0] WR_BASE    = 24'h000000,
    parameter logic [ADDR_WIDTH-1:0] WR_END     = 24'h0003FF,
    parameter logic [ADDR_WIDTH-1:0] RD_BASE    = 24'h000000,
    parameter logic [ADDR_WIDTH-1:0] RD_END     = 24'h0003FF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  usr_wr_en,
    input  logic [DATA_WIDTH-1:0] usr_wr_data,
    output logic                  usr_wr_full,
    input  logic                  usr_rd_en,
    output logic [DATA_WIDTH-1:0] usr_rd_data,
    output logic                  usr_rd_empty,
    input  logic                  init_end_i,
    input  logic                  rd_valid_i,
    input  logic [BLEN_WIDTH-1:0] burst_len_i,
    output logic                  write_req_o,
    output logic                  read_req_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [BLEN_WIDTH-1:0] burst_len_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  wr_ack_i,
    input  logic                  rd_ack_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i
`ifdef DDR_FIFO_ERR_CNT_EN
    ,
    output logic [15:0]           wr_ovf_cnt_o,
    output logic [15:0]           rd_unf_cnt_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t                state;
    state_t                state_n;
    logic                  last_wr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [AW:0]           wr_level;
    logic [AW:0]           rd_level;
    logic                  wr_rdy;
    logic                  rd_rdy;

    ddr_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (usr_wr_en),
        .din   (usr_wr_data),
        .pop   (wr_ack_i),
        .dout  (data_o),
        .level (wr_level)
    );

    ddr_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (rd_ack_i),
        .din   (rd_data_i),
        .pop   (usr_rd_en),
        .dout  (usr_rd_data),
        .level (rd_level)
    );

    assign usr_wr_full  = wr_level[AW];
    assign usr_rd_empty = rd_level == '0;
    assign wr_rdy       = init_end_i && burst_len_o != '0 && int'(wr_level) >= int'(burst_len_o);
    assign rd_rdy       = init_end_i && rd_valid_i && burst_len_o != '0 &&
                          FIFO_DEPTH - int'(rd_level) >= int'(burst_len_o);
    assign write_req_o  = state == WR_REQ && !wr_ack_i;
    assign read_req_o   = state == RD_REQ && !rd_ack_i;
    assign addr_o       = (state == RD_REQ || state == RD_BURST) ? rd_addr : wr_addr;

    // Next state: arbitrate in IDLE (alternate on contention), wait for ack, leave burst on ack falling.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = (wr_rdy && (!rd_rdy || !last_wr)) ? WR_REQ : rd_rdy ? RD_REQ : IDLE;
            WR_REQ:   state_n = wr_ack_i ? WR_BURST : WR_REQ;
            WR_BURST: state_n = wr_ack_i ? WR_BURST : IDLE;
            RD_REQ:   state_n = rd_ack_i ? RD_BURST : RD_REQ;
            RD_BURST: state_n = rd_ack_i ? RD_BURST : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // State, grant history, burst length latch and address advance at the end of each burst.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            last_wr     <= 1'b0;
            burst_len_o <= '0;
            wr_addr     <= WR_BASE;
            rd_addr     <= RD_BASE;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n != IDLE) last_wr <= state_n == WR_REQ;
            if (state == IDLE && state_n == IDLE) burst_len_o <= burst_len_i;
            if (state == WR_BURST && !wr_ack_i) wr_addr <= next_addr(wr_addr, WR_BASE, WR_END, burst_len_o);
            if (state == RD_BURST && !rd_ack_i) rd_addr <= next_addr(rd_addr, RD_BASE, RD_END, burst_len_o);
        end
    end

`ifdef DDR_FIFO_ERR_CNT_EN
    // Saturating counts of pushes dropped on a full write FIFO and pops ignored on an empty read FIFO.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ovf_cnt_o <= '0;
            rd_unf_cnt_o <= '0;
        end else begin
            if (usr_wr_en && usr_wr_full && !wr_ack_i && wr_ovf_cnt_o != 16'hFFFF) wr_ovf_cnt_o <= wr_ovf_cnt_o + 16'd1;
            if (usr_rd_en && usr_rd_empty && rd_unf_cnt_o != 16'hFFFF) rd_unf_cnt_o <= rd_unf_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_fifo_ctrl.sv
// tb_ddr_fifo_ctrl: directed self-checking bench for ddr_fifo_ctrl
module tb_ddr_fifo_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        usr_wr_en = 1'b0;
    logic [15:0] usr_wr_data = '0;
    logic        usr_wr_full;
    logic        usr_rd_en = 1'b0;
    logic [15:0] usr_rd_data;
    logic        usr_rd_empty;
    logic        init_end_i = 1'b0;
    logic        rd_valid_i = 1'b0;
    logic [9:0]  burst_len_i = 10'd8;
    logic        write_req_o;
    logic        read_req_o;
    logic [23:0] addr_o;
    logic [9:0]  burst_len_o;
    logic [15:0] data_o;
    logic        wr_ack_i = 1'b0;
    logic        rd_ack_i = 1'b0;
    logic [15:0] rd_data_i = '0;
`ifdef DDR_FIFO_ERR_CNT_EN
    logic [15:0] wr_ovf_cnt_o;
    logic [15:0] rd_unf_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    ddr_fifo_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .usr_wr_en    (usr_wr_en),
        .usr_wr_data  (usr_wr_data),
        .usr_wr_full  (usr_wr_full),
        .usr_rd_en    (usr_rd_en),
        .usr_rd_data  (usr_rd_data),
        .usr_rd_empty (usr_rd_empty),
        .init_end_i   (init_end_i),
        .rd_valid_i   (rd_valid_i),
        .burst_len_i  (burst_len_i),
        .write_req_o  (write_req_o),
        .read_req_o   (read_req_o),
        .addr_o       (addr_o),
        .burst_len_o  (burst_len_o),
        .data_o       (data_o),
        .wr_ack_i     (wr_ack_i),
        .rd_ack_i     (rd_ack_i),
        .rd_data_i    (rd_data_i)
`ifdef DDR_FIFO_ERR_CNT_EN
        ,
        .wr_ovf_cnt_o (wr_ovf_cnt_o),
        .rd_unf_cnt_o (rd_unf_cnt_o)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push len words, wait (bounded) for the write request, then ack len cycles and drop the ack.
    task automatic wr_burst(input int len);
        int t;
        for (int i = 0; i < len; i++) begin
            usr_wr_en = 1'b1;
            usr_wr_data = 16'(i);
            @(negedge sys_clk);
        end
        usr_wr_en = 1'b0;
        t = 0;
        while (!write_req_o && t < 10) begin
            @(negedge sys_clk);
            t++;
        end
        check("wr_req_seen", write_req_o, 1);
        for (int i = 0; i < len; i++) begin
            wr_ack_i = 1'b1;
            @(negedge sys_clk);
        end
        wr_ack_i = 1'b0;
        @(negedge sys_clk);
    endtask

    initial begin
        repeat (2) @(negedge sys_clk);
        check("rst_write_req", write_req_o, 0);
        check("rst_read_req", read_req_o, 0);
        check("rst_addr", addr_o, 24'h000000);
        check("rst_blen", burst_len_o, 0);
        check("rst_full", usr_wr_full, 0);
        check("rst_empty", usr_rd_empty, 1);

        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("blen_latch8", burst_len_o, 8);
        for (int i = 0; i < 8; i++) begin
            usr_wr_en = 1'b1;
            usr_wr_data = 16'(i + 1);
            @(negedge sys_clk);
        end
        usr_wr_en = 1'b0;
        @(negedge sys_clk);
        check("init_gate", write_req_o, 0);
        init_end_i = 1'b1;
        @(negedge sys_clk);
        check("wr_req", write_req_o, 1);
        check("wr_req_addr", addr_o, 24'h000000);
        check("wr_head", data_o, 16'h0001);
        burst_len_i = 10'd4;
        for (int i = 0; i < 8; i++) begin
            wr_ack_i = 1'b1;
            #1;
            check("wr_data", data_o, 32'(i + 1));
            if (i == 0) check("wr_req_drop", write_req_o, 0);
            if (i == 4) check("blen_hold", burst_len_o, 8);
            @(negedge sys_clk);
        end
        wr_ack_i = 1'b0;
        @(negedge sys_clk);
        check("wr_addr_8", addr_o, 24'h000008);
        @(negedge sys_clk);
        check("blen_latch4", burst_len_o, 4);

        rd_valid_i = 1'b1;
        @(negedge sys_clk);
        check("rd_req", read_req_o, 1);
        check("rd_req_addr", addr_o, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            rd_ack_i = 1'b1;
            rd_data_i = 16'(16'hA0 + i);
            #1;
            if (i == 0) check("rd_req_drop", read_req_o, 0);
            @(negedge sys_clk);
        end
        rd_ack_i = 1'b0;
        rd_valid_i = 1'b0;
        @(negedge sys_clk);
        check("rd_not_empty", usr_rd_empty, 0);
        for (int i = 0; i < 4; i++) begin
            check("rd_pop_data", usr_rd_data, 32'(16'hA0 + i));
            usr_rd_en = 1'b1;
            @(negedge sys_clk);
        end
        check("rd_empty_after", usr_rd_empty, 1);
        @(negedge sys_clk);
        usr_rd_en = 1'b0;
        check("rd_pop_ignored", usr_rd_empty, 1);
`ifdef DDR_FIFO_ERR_CNT_EN
        check("rd_unf_cnt", rd_unf_cnt_o, 1);
`endif

        init_end_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            usr_wr_en = 1'b1;
            usr_wr_data = 16'(16'h11 + i);
            @(negedge sys_clk);
        end
        usr_wr_en = 1'b0;
        rd_valid_i = 1'b1;
        init_end_i = 1'b1;
        @(negedge sys_clk);
        check("arb1_write", write_req_o, 1);
        check("arb1_no_read", read_req_o, 0);
        for (int i = 0; i < 4; i++) begin
            wr_ack_i = 1'b1;
            usr_wr_en = 1'b1;
            usr_wr_data = 16'(16'h15 + i);
            #1;
            check("arb1_data", data_o, 32'(16'h11 + i));
            @(negedge sys_clk);
        end
        wr_ack_i = 1'b0;
        usr_wr_en = 1'b0;
        @(negedge sys_clk);
        check("wr_addr_c", addr_o, 24'h00000C);
        @(negedge sys_clk);
        check("arb2_read", read_req_o, 1);
        check("arb2_no_write", write_req_o, 0);
        check("arb2_addr", addr_o, 24'h000004);
        for (int i = 0; i < 4; i++) begin
            rd_ack_i = 1'b1;
            rd_data_i = 16'(16'hB0 + i);
            @(negedge sys_clk);
        end
        rd_ack_i = 1'b0;
        rd_valid_i = 1'b0;
        init_end_i = 1'b0;
        @(negedge sys_clk);

        init_end_i = 1'b1;
        @(negedge sys_clk);
        check("wr_req_again", write_req_o, 1);
        wr_ack_i = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        wr_ack_i = 1'b0;
        @(negedge sys_clk);
        check("abort_write_req", write_req_o, 0);
        check("abort_read_req", read_req_o, 0);
        check("abort_empty", usr_rd_empty, 1);
        check("abort_addr", addr_o, 24'h000000);
        check("abort_blen", burst_len_o, 0);

        sys_rst_n = 1'b1;
        burst_len_i = 10'd256;
        @(negedge sys_clk);
        repeat (3) wr_burst(256);
        check("wr_addr_300", addr_o, 24'h000300);
        burst_len_i = 10'd8;
        @(negedge sys_clk);
        repeat (31) wr_burst(8);
        check("wr_addr_3f8", addr_o, 24'h0003F8);
        wr_burst(8);
        check("wr_addr_wrap", addr_o, 24'h000000);

        init_end_i = 1'b0;
        for (int i = 0; i < 512; i++) begin
            usr_wr_en = 1'b1;
            usr_wr_data = 16'(16'h100 + i);
            @(negedge sys_clk);
            if (i == 510) check("full_511", usr_wr_full, 0);
        end
        check("full_512", usr_wr_full, 1);
        usr_wr_data = 16'hDEAD;
        @(negedge sys_clk);
        usr_wr_en = 1'b0;
        check("full_513", usr_wr_full, 1);
        check("ovf_head_kept", data_o, 16'h0100);
`ifdef DDR_FIFO_ERR_CNT_EN
        check("wr_ovf_cnt", wr_ovf_cnt_o, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
